// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, signed or unsigned operands.
// Optional macro SEQ_DIVIDER_SAT_EN saturates the signed-overflow quotient instead of wrapping.
module seq_divider #(
  parameter int unsigned N_WIDTH = 8,
  parameter int unsigned D_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sgn,
  input  logic [N_WIDTH-1:0] num,
  input  logic [D_WIDTH-1:0] den,
  output logic [N_WIDTH-1:0] quot,
  output logic [D_WIDTH-1:0] rem,
  output logic               running,
  output logic               done,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int unsigned CntW = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;
  localparam logic [CntW-1:0]    LastStep = CntW'(N_WIDTH - 1);
  localparam logic [N_WIDTH-1:0] NMaxPos  = {1'b0, {(N_WIDTH-1){1'b1}}};
  localparam logic [N_WIDTH-1:0] NMinNeg  = {1'b1, {(N_WIDTH-1){1'b0}}};
  localparam logic [D_WIDTH-1:0] DMinus1  = '1;
`ifdef SEQ_DIVIDER_SAT_EN
  localparam logic [N_WIDTH-1:0] OvfQuot  = NMaxPos;
`else
  localparam logic [N_WIDTH-1:0] OvfQuot  = NMinNeg;
`endif

  typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [N_WIDTH-1:0] qsh_q, qsh_d;   // dividend magnitude shifts out, quotient bits shift in
  logic [D_WIDTH-1:0] prem_q, prem_d;
  logic [D_WIDTH-1:0] dmag_q, dmag_d;
  logic               sgn_q, sgn_d;
  logic               num_neg_q, num_neg_d;
  logic               den_neg_q, den_neg_d;
  logic               dz_q, dz_d;
  logic               ov_q, ov_d;
  logic [N_WIDTH-1:0] quot_q, quot_d;
  logic [D_WIDTH-1:0] rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [D_WIDTH:0]   shifted;
  logic [D_WIDTH+1:0] diff;

  assign shifted = {prem_q, qsh_q[N_WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dmag_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qsh_d     = qsh_q;
    prem_d    = prem_q;
    dmag_d    = dmag_q;
    sgn_d     = sgn_q;
    num_neg_d = num_neg_q;
    den_neg_d = den_neg_q;
    dz_d      = dz_q;
    ov_d      = ov_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sgn_d     = sgn;
          num_neg_d = sgn & num[N_WIDTH-1];
          den_neg_d = sgn & den[D_WIDTH-1];
          qsh_d     = (sgn & num[N_WIDTH-1]) ? -num : num;
          dmag_d    = (sgn & den[D_WIDTH-1]) ? -den : den;
          dz_d      = (den == '0);
          ov_d      = sgn & (num == NMinNeg) & (den == DMinus1);
          prem_d    = '0;
          cnt_d     = '0;
          state_d   = StIter;
        end
      end
      StIter: begin
        // Restoring step: keep the subtraction only when it does not borrow
        if (!diff[D_WIDTH+1]) begin
          prem_d = diff[D_WIDTH-1:0];
          qsh_d  = {qsh_q[N_WIDTH-2:0], 1'b1};
        end else begin
          prem_d = shifted[D_WIDTH-1:0];
          qsh_d  = {qsh_q[N_WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastStep) begin
          state_d = StFix;
        end
      end
      StFix: begin
        quot_d = (num_neg_q ^ den_neg_q) ? -qsh_q : qsh_q;
        rem_d  = num_neg_q ? -prem_q : prem_q;
        if (dz_q) begin
          quot_d = !sgn_q ? '1 : (num_neg_q ? NMinNeg : NMaxPos);
          rem_d  = '0;
        end else if (ov_q) begin
          quot_d = OvfQuot;
          rem_d  = '0;
        end
        dbz_d   = dz_q;
        ovf_d   = ov_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      qsh_q     <= '0;
      prem_q    <= '0;
      dmag_q    <= '0;
      sgn_q     <= 1'b0;
      num_neg_q <= 1'b0;
      den_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      ov_q      <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qsh_q     <= qsh_d;
      prem_q    <= prem_d;
      dmag_q    <= dmag_d;
      sgn_q     <= sgn_d;
      num_neg_q <= num_neg_d;
      den_neg_q <= den_neg_d;
      dz_q      <= dz_d;
      ov_q      <= ov_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign running     = (state_q != StIdle);
  assign done        = done_q;
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N_WIDTH, default 8, meaning dividend and quotient width.
REQ-002 SHALL have parameter D_WIDTH, default 4, meaning divisor and remainder width (D_WIDTH < N_WIDTH).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit, request to begin one division.
REQ-006 SHALL have port sgn, input, 1 bit: 1 = two's-complement operands and results, 0 = unsigned.
REQ-007 SHALL have port num, input, N_WIDTH bits, the dividend.
REQ-008 SHALL have port den, input, D_WIDTH bits, the divisor.
REQ-009 SHALL have port quot, output, N_WIDTH bits, the quotient.
REQ-010 SHALL have port rem, output, D_WIDTH bits, the remainder.
REQ-011 SHALL have port running, output, 1 bit, high while a division is in progress.
REQ-012 SHALL have port done, output, 1 bit, a one-cycle pulse when quot and rem become valid.
REQ-013 SHALL have port div_by_zero, output, 1 bit, set when den was 0.
REQ-014 SHALL have port overflow, output, 1 bit, set when the signed quotient is not representable.

Function
REQ-015 SHALL implement FSM states IDLE, ITER and FIX, with IDLE as the reset state.
REQ-016 SHALL, in IDLE with start=1 at an edge, latch sgn, num and den, store the magnitudes of num and den (abs when sgn=1), and go to ITER with the step counter at 0.
REQ-017 SHALL perform one restoring shift/subtract step per cycle in ITER, N_WIDTH cycles in total, then go to FIX.
REQ-018 SHALL, in FIX, apply signs for one cycle: quotient negated if the operand signs differ; remainder takes the sign of the dividend (truncation toward zero); then return to IDLE.
REQ-019 SHALL hold running high in ITER and FIX: N_WIDTH+1 cycles, starting the cycle after start is sampled.
REQ-020 SHALL raise done for exactly one cycle, the first IDLE cycle after FIX; quot, rem, div_by_zero and overflow update on the same edge.
REQ-021 SHALL hold quot, rem and both flags until the next done; they SHALL NOT change during a later computation.
REQ-022 SHALL ignore start while running=1; no queuing.
REQ-023 SHALL accept start in the same cycle that done=1, and running SHALL rise next cycle.
REQ-024 SHALL handle den=0 with unchanged timing: div_by_zero=1, rem=0; quot = all ones if unsigned, otherwise the maximum positive value if num>=0 or the minimum negative value if num<0.
REQ-025 SHALL handle signed overflow (num = minimum negative, den = -1) by setting overflow=1, with rem=0 and quot per REQ-031.
REQ-026 SHALL clear both flags on every done where they do not apply.
REQ-027 SHALL read operands only at the start edge; input changes afterwards SHALL have no effect.

Reset
REQ-028 SHALL, while reset=1, force: state IDLE, counter 0, quot=0, rem=0, running=0, done=0, div_by_zero=0, overflow=0.
REQ-029 SHALL give reset priority over start.
REQ-030 SHALL, on reset during ITER or FIX, abort the operation without a done pulse; a start in the first cycle after reset is released SHALL be accepted.

Configuration
REQ-031 SHALL use macro SEQ_DIVIDER_SAT_EN: when defined, the signed-overflow quotient saturates to the maximum positive value (127 at default widths); when undefined, it wraps to the minimum negative value (-128). The overflow flag, timing and all other cases SHALL be identical in both builds.

Verification
REQ-032 SHALL cover: unsigned, num=200, den=7 -> done 10 cycles after start (running high 9 cycles), quot=28, rem=4, both flags 0.
REQ-033 SHALL cover: signed, num=-100, den=7 -> quot=-14, rem=-2; and num=100, den=-7 -> quot=-14, rem=2.
REQ-034 SHALL cover: den=0 with signed num=-5 -> quot=-128, rem=0, div_by_zero=1; unsigned num=9 -> quot=255.
REQ-035 SHALL cover: signed num=-128, den=-1 -> overflow=1, rem=0; quot=127 with SEQ_DIVIDER_SAT_EN defined, -128 without.
REQ-036 SHALL cover: start re-pulsed mid-ITER with other operands -> ignored, first result intact; reset asserted mid-ITER -> no done, outputs 0.
REQ-037 SHALL cover: exhaustive sweep of all num and den values in both sgn modes, back-to-back starts on done -> every result matches a reference model, and done count equals start count.
